// File: rtl/freq_sort_engine.sv
// Frame symbol histogram followed by an odd-even transposition sort on {freq, symbol}.
// Optional macro FREQ_SAT_EN: counters saturate instead of wrapping.
module freq_sort_engine #(
  parameter int unsigned SYMBOLS      = 16,
  parameter int unsigned SYMBOL_WIDTH = 5,
  parameter int unsigned FREQ_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic [SYMBOL_WIDTH-1:0]    sym_in_i,
  input  logic                       sym_valid_i,
  input  logic                       sym_last_i,
  output logic                       sym_ready_o,
  output logic [FREQ_WIDTH-1:0]      out_freq_o,
  output logic [SYMBOL_WIDTH-1:0]    out_sym_o,
  output logic                       out_valid_o,
  output logic                       out_last_o,
  input  logic                       out_ready_i,
  output logic [$clog2(SYMBOLS+1)-1:0] nonzero_count_o,
  output logic                       busy_o,
  output logic                       overflow_o,
  output logic                       bad_symbol_o
);

  localparam int unsigned IW  = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
  localparam int unsigned NZW = $clog2(SYMBOLS + 1);

  typedef enum logic [1:0] {StCount, StLoad, StSort, StEmit} state_e;

  state_e                  state_q;
  logic [FREQ_WIDTH-1:0]   cnt_q     [SYMBOLS];
  logic [FREQ_WIDTH-1:0]   sb_freq_q [SYMBOLS];
  logic [SYMBOL_WIDTH-1:0] sb_sym_q  [SYMBOLS];
  logic [FREQ_WIDTH-1:0]   sort_freq [SYMBOLS];
  logic [SYMBOL_WIDTH-1:0] sort_sym  [SYMBOLS];
  logic [IW-1:0]           pass_q, idx_q;
  logic [NZW-1:0]          nz_q, nz_calc;
  logic                    overflow_q, bad_q;
  logic                    accept, in_range, emit_last;

  assign sym_ready_o     = (state_q == StCount);
  assign busy_o          = (state_q != StCount);
  assign out_valid_o     = (state_q == StEmit);
  assign out_last_o      = out_valid_o && (idx_q == IW'(SYMBOLS - 1));
  assign out_freq_o      = out_valid_o ? sb_freq_q[idx_q] : '0;
  assign out_sym_o       = out_valid_o ? sb_sym_q[idx_q] : '0;
  assign nonzero_count_o = nz_q;
  assign overflow_o      = overflow_q;
  assign bad_symbol_o    = bad_q;

  assign accept    = sym_valid_i && sym_ready_o;
  assign in_range  = 32'(sym_in_i) < SYMBOLS;
  assign emit_last = out_last_o && out_ready_i;

  always_comb begin
    nz_calc = '0;
    for (int i = 0; i < SYMBOLS; i++) begin
      nz_calc = nz_calc + NZW'(cnt_q[i] != '0);
    end
  end

  // One transposition pass: pairs start at 0 on even passes, at 1 on odd passes.
  always_comb begin
    for (int i = 0; i < SYMBOLS; i++) begin
      sort_freq[i] = sb_freq_q[i];
      sort_sym[i]  = sb_sym_q[i];
    end
    for (int i = 0; i < SYMBOLS - 1; i++) begin
      if ((((i % 2) != 0) == pass_q[0]) &&
          ({sb_freq_q[i], sb_sym_q[i]} > {sb_freq_q[i+1], sb_sym_q[i+1]})) begin
        sort_freq[i]   = sb_freq_q[i+1];
        sort_sym[i]    = sb_sym_q[i+1];
        sort_freq[i+1] = sb_freq_q[i];
        sort_sym[i+1]  = sb_sym_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StCount;
      pass_q     <= '0;
      idx_q      <= '0;
      nz_q       <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
      for (int i = 0; i < SYMBOLS; i++) begin
        cnt_q[i]     <= '0;
        sb_freq_q[i] <= '0;
        sb_sym_q[i]  <= '0;
      end
    end else if (clear_i) begin
      state_q    <= StCount;
      pass_q     <= '0;
      idx_q      <= '0;
      nz_q       <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
      for (int i = 0; i < SYMBOLS; i++) begin
        cnt_q[i]     <= '0;
        sb_freq_q[i] <= '0;
        sb_sym_q[i]  <= '0;
      end
    end else begin
      unique case (state_q)
        StCount: begin
          if (accept) begin
            if (in_range) begin
              for (int i = 0; i < SYMBOLS; i++) begin
                if (sym_in_i == SYMBOL_WIDTH'(i)) begin
                  if (cnt_q[i] == '1) overflow_q <= 1'b1;
`ifdef FREQ_SAT_EN
                  if (cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + FREQ_WIDTH'(1);
`else
                  cnt_q[i] <= cnt_q[i] + FREQ_WIDTH'(1);
`endif
                end
              end
            end else begin
              bad_q <= 1'b1;
            end
            if (sym_last_i) state_q <= StLoad;
          end
        end
        StLoad: begin
          for (int i = 0; i < SYMBOLS; i++) begin
            sb_freq_q[i] <= cnt_q[i];
            sb_sym_q[i]  <= SYMBOL_WIDTH'(i);
          end
          nz_q    <= nz_calc;
          pass_q  <= '0;
          idx_q   <= '0;
          state_q <= StSort;
        end
        StSort: begin
          for (int i = 0; i < SYMBOLS; i++) begin
            sb_freq_q[i] <= sort_freq[i];
            sb_sym_q[i]  <= sort_sym[i];
          end
          pass_q <= pass_q + IW'(1);
          if (pass_q == IW'(SYMBOLS - 1)) state_q <= StEmit;
        end
        StEmit: begin
          if (emit_last) begin
            state_q    <= StCount;
            idx_q      <= '0;
            nz_q       <= '0;
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
            for (int i = 0; i < SYMBOLS; i++) cnt_q[i] <= '0;
          end else if (out_ready_i) begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: state_q <= StCount;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_sort_engine.sv
// Directed bench: instance A (16 symbols, 16-bit counts) and B (10 symbols, 4-bit counts).
module tb_freq_sort_engine;

  logic       clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic [4:0] sym = '0;
  logic       valid = 1'b0, last = 1'b0, out_ready = 1'b0, sel = 1'b0;

  logic        rdy_a, val_a, lst_a, busy_a, ovf_a, bad_a;
  logic [15:0] f_a;
  logic [4:0]  s_a, nz_a;
  logic        rdy_b, val_b, lst_b, busy_b, ovf_b, bad_b;
  logic [3:0]  f_b, nz_b;
  logic [4:0]  s_b;

  logic        o_ready, o_valid, o_last, o_busy, o_ovf, o_bad;
  logic [15:0] o_freq;
  logic [4:0]  o_sym, o_nz;

  assign o_ready = sel ? rdy_b : rdy_a;
  assign o_valid = sel ? val_b : val_a;
  assign o_last  = sel ? lst_b : lst_a;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_ovf   = sel ? ovf_b : ovf_a;
  assign o_bad   = sel ? bad_b : bad_a;
  assign o_freq  = sel ? {12'd0, f_b} : f_a;
  assign o_sym   = sel ? s_b : s_a;
  assign o_nz    = sel ? {1'b0, nz_b} : nz_a;

  always #5 clk = ~clk;

  freq_sort_engine u_dut_a (
    .clk(clk), .reset(reset), .clear_i(clear),
    .sym_in_i(sym), .sym_valid_i(valid & ~sel), .sym_last_i(last), .sym_ready_o(rdy_a),
    .out_freq_o(f_a), .out_sym_o(s_a), .out_valid_o(val_a), .out_last_o(lst_a),
    .out_ready_i(out_ready & ~sel), .nonzero_count_o(nz_a), .busy_o(busy_a),
    .overflow_o(ovf_a), .bad_symbol_o(bad_a)
  );

  freq_sort_engine #(.SYMBOLS(10), .SYMBOL_WIDTH(5), .FREQ_WIDTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .clear_i(clear),
    .sym_in_i(sym), .sym_valid_i(valid & sel), .sym_last_i(last), .sym_ready_o(rdy_b),
    .out_freq_o(f_b), .out_sym_o(s_b), .out_valid_o(val_b), .out_last_o(lst_b),
    .out_ready_i(out_ready & sel), .nonzero_count_o(nz_b), .busy_o(busy_b),
    .overflow_o(ovf_b), .bad_symbol_o(bad_b)
  );

  int n_checks = 0, n_fail = 0;
  int got_f[16], got_s[16];
  int cur_n, nlast, last_pos, hold_bad, lat;
  int exp_s[16] = '{0, 2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 15, 7, 1, 3};
  int exp_f[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
`ifdef FREQ_SAT_EN
  int exp_wrap = 15;
`else
  int exp_wrap = 1;
`endif

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input bit l);
    int g = 0;
    sym   = 5'(s);
    last  = l;
    valid = 1'b1;
    while (!o_ready && g < 100) begin
      tick();
      g++;
    end
    check("send_ready", int'(o_ready), 1);
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  // Called one cycle after the last accept; reports cycles until out_valid.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!o_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    if (!o_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic drain(input int n, input bit toggle);
    int k = 0, cyc = 0;
    bit rdy, held = 1'b0;
    int hf = 0, hs = 0;
    nlast = 0; last_pos = -1; hold_bad = 0; cur_n = n;
    while (k < n && cyc < 400) begin
      rdy = toggle ? ((cyc % 2) == 1) : 1'b1;
      out_ready = rdy;
      if (o_valid) begin
        if (held && (int'(o_freq) != hf || int'(o_sym) != hs)) hold_bad++;
        if (rdy) begin
          got_f[k] = int'(o_freq);
          got_s[k] = int'(o_sym);
          if (o_last) begin
            nlast++;
            last_pos = k;
          end
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hf = int'(o_freq);
          hs = int'(o_sym);
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_count", k, n);
    check("post_valid", int'(o_valid), 0);
    check("post_ready", int'(o_ready), 1);
  endtask

  function automatic int freq_of(input int s);
    for (int i = 0; i < cur_n; i++) if (got_s[i] == s) return got_f[i];
    return -1;
  endfunction

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();

    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #0;
      check("rst_ready", int'(o_ready), 1);
      check("rst_valid", int'(o_valid), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_flags", int'({o_ovf, o_bad, o_last}), 0);
      check("rst_nz", int'(o_nz), 0);
      check("rst_freq", int'(o_freq), 0);
    end

    // 1: basic frame, latency and full order
    sel = 1'b0;
    send(3, 0); send(3, 0); send(3, 0); send(1, 0); send(1, 0); send(7, 1);
    check("t1_busy", int'(o_busy), 1);
    wait_valid(lat);
    check("t1_latency", lat, 18);
    check("t1_nz", int'(o_nz), 3);
    drain(16, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t1_sym%0d", i), got_s[i], exp_s[i]);
      check($sformatf("t1_freq%0d", i), got_f[i], exp_f[i]);
    end
    check("t1_last_pos", last_pos, 15);

    // 3: back-pressure toggling
    send(5, 0); send(5, 0); send(9, 1);
    wait_valid(lat);
    drain(16, 1);
    check("t3_hold", hold_bad, 0);
    check("t3_nlast", nlast, 1);
    check("t3_last_pos", last_pos, 15);
    check("t3_top_sym", got_s[15], 5);
    check("t3_top_freq", got_f[15], 2);
    check("t3_mid_sym", got_s[14], 9);

    // 4: out-of-range symbol, input ignored while sorting
    sel = 1'b1;
    send(12, 0); send(4, 1);
    tick();
    sym = 5'd4; valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_ready_sort", int'(o_ready), 0);
      tick();
    end
    valid = 1'b0;
    wait_valid(lat);
    check("t4_bad", int'(o_bad), 1);
    check("t4_nz", int'(o_nz), 1);
    drain(10, 0);
    check("t4_top_sym", got_s[9], 4);
    check("t4_top_freq", got_f[9], 1);
    check("t4_zero0", freq_of(0), 0);
    check("t4_bad_clr", int'(o_bad), 0);

    // 2: counter wrap / saturation on 4-bit counters
    for (int i = 0; i < 17; i++) send(2, i == 16);
    wait_valid(lat);
    check("t2_ovf", int'(o_ovf), 1);
    check("t2_nz", int'(o_nz), 1);
    drain(10, 0);
    check("t2_freq2", freq_of(2), exp_wrap);
    check("t2_top_sym", got_s[9], 2);
    check("t2_ovf_clr", int'(o_ovf), 0);

    // 5: reset during sort, then clear during emit
    sel = 1'b0;
    send(1, 0); send(1, 0); send(8, 1);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("t5_rst_busy", int'(o_busy), 0);
    check("t5_rst_ready", int'(o_ready), 1);
    tick();
    reset = 1'b0;
    send(5, 1);
    wait_valid(lat);
    check("t5_nz", int'(o_nz), 1);
    drain(16, 0);
    check("t5_f5", freq_of(5), 1);
    check("t5_f1", freq_of(1), 0);
    check("t5_f8", freq_of(8), 0);

    send(2, 0); send(3, 1);
    wait_valid(lat);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_clr_valid", int'(o_valid), 0);
    check("t5_clr_ready", int'(o_ready), 1);
    send(5, 1);
    wait_valid(lat);
    check("t5c_nz", int'(o_nz), 1);
    drain(16, 0);
    check("t5c_f5", freq_of(5), 1);
    check("t5c_f2", freq_of(2), 0);
    check("t5c_f3", freq_of(3), 0);

    // 6: back-to-back frames
    send(1, 0); send(1, 1);
    wait_valid(lat);
    drain(16, 0);
    check("t6a_f1", freq_of(1), 2);
    send(2, 1);
    wait_valid(lat);
    drain(16, 0);
    check("t6b_f1", freq_of(1), 0);
    check("t6b_f2", freq_of(2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
